// File: rtl/mux_pkg.sv
// Shared definitions for the 2:1 selector: default width and select encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mux_pkg;

  localparam int DEFAULT_WIDTH = 1;

  // Select encoding: 0 routes in1, 1 routes in2.
  typedef enum logic {
    SEL_IN1 = 1'b0,
    SEL_IN2 = 1'b1
  } sel_e;

endpackage : mux_pkg

// File: rtl/mux_2x1_reg.sv
// WIDTH-bit flop with asynchronous active-low clear to zero.
// Latency: one clk cycle from d to q.
// Backpressure: none; loads every rising edge.
module mux_2x1_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d each edge; clear immediately when reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule : mux_2x1_reg

// File: rtl/mux_2x1.sv
// 2:1 data selector with registered copy of the output and a select-change strobe.
// Latency: out is combinational; out_q and sel_chg are one cycle after the sampling edge.
// Backpressure: none; new inputs are accepted every cycle.
module mux_2x1
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_chg
);

  logic s_q;
  logic sel_chg_d;

  // Select the source; an unknown select propagates X rather than picking a side.
  always_comb begin
    out = 'x;
    case (s)
      SEL_IN1: out = in1;
      SEL_IN2: out = in2;
      default: out = 'x;
    endcase
  end

  // A change is seen only between edge-sampled selects, so glitches between edges are ignored.
  assign sel_chg_d = (s != s_q);

  mux_2x1_reg #(.WIDTH(WIDTH)) u_out_q (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (out),
    .q     (out_q)
  );

  mux_2x1_reg #(.WIDTH(1)) u_s_q (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (s),
    .q     (s_q)
  );

  mux_2x1_reg #(.WIDTH(1)) u_sel_chg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sel_chg_d),
    .q     (sel_chg)
  );

endmodule : mux_2x1

// File: tb/tb_mux_2x1.sv
// Directed bench for mux_2x1 at WIDTH=1 and WIDTH=8.
// Latency: checks out at zero cycles, out_q and sel_chg one edge later.
// Backpressure: not applicable.
module tb_mux_2x1;
  import mux_pkg::*;

  logic       clk;
  logic       clk_en;
  logic       rst_n;

  logic       s1;
  logic [0:0] a1, b1, o1, oq1;
  logic       c1;

  logic       s8;
  logic [7:0] a8, b8, o8, oq8;
  logic       c8;

  int total;
  int passed;

  mux_2x1 #(.WIDTH(1)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .s       (s1),
    .in1     (a1),
    .in2     (b1),
    .out     (o1),
    .out_q   (oq1),
    .sel_chg (c1)
  );

  mux_2x1 #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .s       (s8),
    .in1     (a8),
    .in2     (b8),
    .out     (o8),
    .out_q   (oq8),
    .sel_chg (c8)
  );

  // 10 ns clock, gated so reset can be exercised with the clock stopped.
  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    clk    = 1'b0;
    clk_en = 1'b0;
    rst_n  = 1'b1;
    s1 = SEL_IN1; a1 = 1'b0; b1 = 1'b0;
    s8 = SEL_IN1; a8 = 8'h00; b8 = 8'h00;
    #3;

    // Async reset with clock stopped
    rst_n = 1'b0;
    #1;
    check("rst_oq1", oq1, 8'h00);
    check("rst_chg1", c1, 8'h00);
    check("rst_oq8", oq8, 8'h00);
    check("rst_chg8", c8, 8'h00);
    s1 = SEL_IN1; a1 = 1'b1; b1 = 1'b0;
    #1;
    check("rst_out_comb", o1, 8'h01);
    #5;
    rst_n  = 1'b1;
    #1;
    clk_en = 1'b1;
    tick();

    // Truth table, WIDTH=1
    s1 = SEL_IN1; a1 = 1'b1; b1 = 1'b0; #1;
    check("tt0_out", o1, 8'h01); tick();
    check("tt0_oq", oq1, 8'h01);
    s1 = SEL_IN1; a1 = 1'b0; b1 = 1'b1; #1;
    check("tt1_out", o1, 8'h00); tick();
    check("tt1_oq", oq1, 8'h00);
    s1 = SEL_IN2; a1 = 1'b1; b1 = 1'b0; #1;
    check("tt2_out", o1, 8'h00); tick();
    check("tt2_oq", oq1, 8'h00);
    s1 = SEL_IN2; a1 = 1'b0; b1 = 1'b1; #1;
    check("tt3_out", o1, 8'h01); tick();
    check("tt3_oq", oq1, 8'h01);

    // Select strobe
    s1 = SEL_IN1;
    tick();
    tick();
    check("chg_hold0_a", c1, 8'h00);
    tick();
    check("chg_hold0_b", c1, 8'h00);
    s1 = SEL_IN2;
    tick();
    check("chg_rise", c1, 8'h01);
    tick();
    check("chg_rise_end", c1, 8'h00);
    tick();
    check("chg_rise_quiet", c1, 8'h00);
    s1 = SEL_IN1;
    tick();
    check("chg_fall", c1, 8'h01);
    tick();
    check("chg_fall_end", c1, 8'h00);

    // Glitch filter: s toggles 0->1->0 between edges
    a1 = 1'b1; b1 = 1'b0; #1;
    s1 = SEL_IN2; #1;
    check("glitch_out_hi", o1, 8'h00);
    s1 = SEL_IN1; #1;
    check("glitch_out_lo", o1, 8'h01);
    tick();
    check("glitch_chg_a", c1, 8'h00);
    tick();
    check("glitch_chg_b", c1, 8'h00);

    // Wide data, WIDTH=8
    a8 = 8'hA5; b8 = 8'h3C; s8 = SEL_IN1; #1;
    check("w_out_a5", o8, 8'hA5);
    tick();
    check("w_oq_a5", oq8, 8'hA5);
    s8 = SEL_IN2; #1;
    check("w_out_3c", o8, 8'h3C);
    check("w_oq_lag", oq8, 8'hA5);
    tick();
    check("w_oq_3c", oq8, 8'h3C);
    check("w_chg", c8, 8'h01);
    tick();
    check("w_oq_hold", oq8, 8'h3C);
    check("w_chg_end", c8, 8'h00);

    // Reset mid-stream between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_oq", oq8, 8'h00);
    check("mid_rst_chg", c8, 8'h00);
    check("mid_rst_out", o8, 8'h3C);
    rst_n = 1'b1;
    tick();
    check("post_rst_oq", oq8, 8'h3C);
    check("post_rst_chg", c8, 8'h01);

    // Simultaneous select and data change
    s8 = SEL_IN1; a8 = 8'h5A;
    tick();
    check("simul_oq", oq8, 8'h5A);
    check("simul_chg", c8, 8'h01);

    clk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_mux_2x1
